// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the execute-stage ALU issue controller: widths, ALU op codes, forward selects.
package alu_issue_ctrl_pkg;

  localparam int WORD_SIZE = 32;
  localparam int REG_AW    = 5;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SUB = 3'b001;
  localparam logic [2:0] F3_MUL = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  // Operand source chosen at accept time
  localparam logic [1:0] FWD_NONE = 2'd0;  // register-file / immediate value
  localparam logic [1:0] FWD_E    = 2'd1;  // producer still in E: take alu_out next cycle
  localparam logic [1:0] FWD_R    = 2'd2;  // producer in R: take wb_data now

endpackage

// File: rtl/alu_fwd_sel.sv
// Combinational RAW-hazard compare of incoming rs1/rs2 against the E and R destinations.
// Zero latency; no handshake of its own (the caller qualifies the result with its accept).
module alu_fwd_sel
  import alu_issue_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              b_is_reg_i,
  input  logic              e_vld_i,
  input  logic [REG_AW-1:0] e_rd_i,
  input  logic              r_vld_i,
  input  logic [REG_AW-1:0] r_rd_i,
  output logic [1:0]        sel_a_o,
  output logic [1:0]        sel_b_o
);

  // x0 is hardwired, so index 0 never creates a dependency; the younger producer (E) wins.
  function automatic logic [1:0] pick_src(
    input logic [REG_AW-1:0] rs,
    input logic              e_vld,
    input logic [REG_AW-1:0] e_rd,
    input logic              r_vld,
    input logic [REG_AW-1:0] r_rd
  );
    logic [1:0] sel;
    sel = FWD_NONE;
    if (rs != '0) begin
      if (e_vld && (rs == e_rd)) begin
        sel = FWD_E;
      end else if (r_vld && (rs == r_rd)) begin
        sel = FWD_R;
      end
    end
    return sel;
  endfunction

  always_comb begin
    sel_a_o = pick_src(rs1_i, e_vld_i, e_rd_i, r_vld_i, r_rd_i);
    sel_b_o = FWD_NONE;
    if (b_is_reg_i) begin
      sel_b_o = pick_src(rs2_i, e_vld_i, e_rd_i, r_vld_i, r_rd_i);
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue register E feeding a registered ALU, result slot R to writeback; accept->wb_valid is 2 edges.
// wb_ready low stalls R, which holds E and drops in_ready; the stalled result is frozen in hold_q.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_funct3,
  input  logic [WORD_SIZE-1:0] in_op_a,
  input  logic [WORD_SIZE-1:0] in_op_b,
  input  logic [REG_AW-1:0]    in_rs1,
  input  logic [REG_AW-1:0]    in_rs2,
  input  logic                 in_b_is_reg,
  input  logic [REG_AW-1:0]    in_rd,
  input  logic                 flush,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [2:0]           alu_ctrl,
  input  logic [WORD_SIZE-1:0] alu_out,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [REG_AW-1:0]    wb_rd,
  output logic [WORD_SIZE-1:0] wb_data
);

  logic                 e_vld_q, e_vld_d;
  logic [2:0]           e_f3_q, e_f3_d;
  logic [WORD_SIZE-1:0] e_a_q, e_a_d;
  logic [WORD_SIZE-1:0] e_b_q, e_b_d;
  logic [REG_AW-1:0]    e_rd_q, e_rd_d;
  logic                 fwd_a_q, fwd_a_d;
  logic                 fwd_b_q, fwd_b_d;
  logic                 r_vld_q, r_vld_d;
  logic [REG_AW-1:0]    r_rd_q, r_rd_d;
  logic                 hold_v_q, hold_v_d;
  logic [WORD_SIZE-1:0] hold_q, hold_d;

  logic       r_stall;
  logic       r_retire;
  logic       e_adv;
  logic       e_fire;
  logic       accept;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  alu_fwd_sel u_fwd_sel (
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .b_is_reg_i (in_b_is_reg),
    .e_vld_i    (e_vld_q),
    .e_rd_i     (e_rd_q),
    .r_vld_i    (r_vld_q),
    .r_rd_i     (r_rd_q),
    .sel_a_o    (sel_a),
    .sel_b_o    (sel_b)
  );

  assign r_stall  = r_vld_q && !wb_ready;
  assign r_retire = r_vld_q && wb_ready;
  assign e_adv    = e_vld_q && !r_stall;
  // A flushed op must not reach R even if it would have advanced this edge
  assign e_fire   = e_adv && !flush;
  assign in_ready = !e_vld_q || !r_stall;
  assign accept   = in_valid && in_ready && !flush;

  assign alu_a    = fwd_a_q ? alu_out : e_a_q;
  assign alu_b    = fwd_b_q ? alu_out : e_b_q;
  assign alu_ctrl = e_f3_q;

  assign wb_valid = r_vld_q;
  assign wb_rd    = r_rd_q;
  assign wb_data  = hold_v_q ? hold_q : alu_out;

  always_comb begin
    e_vld_d  = e_vld_q;
    e_f3_d   = e_f3_q;
    e_a_d    = e_a_q;
    e_b_d    = e_b_q;
    e_rd_d   = e_rd_q;
    fwd_a_d  = fwd_a_q;
    fwd_b_d  = fwd_b_q;
    r_vld_d  = r_vld_q;
    r_rd_d   = r_rd_q;
    hold_v_d = hold_v_q;
    hold_d   = hold_q;

    if (accept) begin
      e_vld_d = 1'b1;
      e_f3_d  = in_funct3;
      e_rd_d  = in_rd;
      e_a_d   = (sel_a == FWD_R) ? wb_data : in_op_a;
      e_b_d   = (sel_b == FWD_R) ? wb_data : in_op_b;
      fwd_a_d = (sel_a == FWD_E);
      fwd_b_d = (sel_b == FWD_E);
    end else if (e_adv) begin
      e_vld_d = 1'b0;
      fwd_a_d = 1'b0;
      fwd_b_d = 1'b0;
    end else if (e_vld_q) begin
      // Producer's result is on alu_out for exactly this cycle; capture it before it moves on
      if (fwd_a_q) begin
        e_a_d   = alu_out;
        fwd_a_d = 1'b0;
      end
      if (fwd_b_q) begin
        e_b_d   = alu_out;
        fwd_b_d = 1'b0;
      end
    end

    if (flush) begin
      e_vld_d = 1'b0;
      fwd_a_d = 1'b0;
      fwd_b_d = 1'b0;
    end

    if (e_fire) begin
      r_vld_d = 1'b1;
      r_rd_d  = e_rd_q;
    end else if (r_retire) begin
      r_vld_d = 1'b0;
    end

    if (r_retire) begin
      hold_v_d = 1'b0;
    end else if (r_stall && !hold_v_q) begin
      hold_v_d = 1'b1;
      hold_d   = alu_out;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_vld_q  <= 1'b0;
      e_f3_q   <= '0;
      e_a_q    <= '0;
      e_b_q    <= '0;
      e_rd_q   <= '0;
      fwd_a_q  <= 1'b0;
      fwd_b_q  <= 1'b0;
      r_vld_q  <= 1'b0;
      r_rd_q   <= '0;
      hold_v_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      e_vld_q  <= e_vld_d;
      e_f3_q   <= e_f3_d;
      e_a_q    <= e_a_d;
      e_b_q    <= e_b_d;
      e_rd_q   <= e_rd_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      r_vld_q  <= r_vld_d;
      r_rd_q   <= r_rd_d;
      hold_v_q <= hold_v_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a one-cycle registered ALU model on alu_a/alu_b/alu_ctrl.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid, in_ready, in_b_is_reg, flush;
  logic [2:0]           in_funct3, alu_ctrl;
  logic [WORD_SIZE-1:0] in_op_a, in_op_b, alu_a, alu_b, alu_out, wb_data;
  logic [REG_AW-1:0]    in_rs1, in_rs2, in_rd, wb_rd;
  logic                 wb_valid, wb_ready;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_op_a(in_op_a), .in_op_b(in_op_b), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_b_is_reg(in_b_is_reg), .in_rd(in_rd), .flush(flush),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [WORD_SIZE-1:0] alu_fn(input logic [2:0] f,
      input logic [WORD_SIZE-1:0] a, input logic [WORD_SIZE-1:0] b);
    case (f)
      F3_ADD:  return a + b;
      F3_SUB:  return a - b;
      F3_MUL:  return a * b;
      F3_AND:  return a & b;
      F3_OR:   return a | b;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) alu_out <= alu_fn(alu_ctrl, alu_a, alu_b);

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [2:0] f, input int a, input int b,
      input int rs1, input int rs2, input logic breg, input int rd);
    in_valid    = 1'b1;
    in_funct3   = f;
    in_op_a     = WORD_SIZE'(a);
    in_op_b     = WORD_SIZE'(b);
    in_rs1      = REG_AW'(rs1);
    in_rs2      = REG_AW'(rs2);
    in_b_is_reg = breg;
    in_rd       = REG_AW'(rd);
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (alu_a !== 32'd0) begin n_err++; $display("FAIL rst_alu_a got=%0d exp=0", alu_a); end
    n_cmp++; if (alu_b !== 32'd0) begin n_err++; $display("FAIL rst_alu_b got=%0d exp=0", alu_b); end
    n_cmp++; if (alu_ctrl !== 3'd0) begin n_err++; $display("FAIL rst_alu_ctrl got=%0d exp=0", alu_ctrl); end
    #19 rst = 1'b1;
    step();
  endtask

  task automatic test_basic_add();
    drive_op(F3_ADD, 5, 7, 1, 2, 1'b1, 3);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (alu_a !== 32'd5) begin n_err++; $display("FAIL basic_alu_a got=%0d exp=5", alu_a); end
    n_cmp++; if (alu_b !== 32'd7) begin n_err++; $display("FAIL basic_alu_b got=%0d exp=7", alu_b); end
    n_cmp++; if (alu_ctrl !== F3_ADD) begin n_err++; $display("FAIL basic_alu_ctrl got=%0d exp=%0d", alu_ctrl, F3_ADD); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_wb got=%b exp=0", wb_valid); end
    step();
    n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL basic_wb_valid got=%b exp=1", wb_valid); end
    n_cmp++; if (wb_rd !== 5'd3) begin n_err++; $display("FAIL basic_wb_rd got=%0d exp=3", wb_rd); end
    n_cmp++; if (wb_data !== 32'd12) begin n_err++; $display("FAIL basic_wb_data got=%0d exp=12", wb_data); end
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL basic_wb_clear got=%b exp=0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    drive_op(F3_ADD, 5, 7, 1, 2, 1'b1, 3);
    step();
    // rs2 equals E.rd but b is an immediate, so only a may forward
    drive_op(F3_SUB, 99, 2, 3, 3, 1'b0, 4);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (alu_a !== 32'd12) begin n_err++; $display("FAIL b2b_fwd_a got=%0d exp=12", alu_a); end
    n_cmp++; if (alu_b !== 32'd2) begin n_err++; $display("FAIL b2b_imm_b got=%0d exp=2", alu_b); end
    n_cmp++; if (wb_rd !== 5'd3 || wb_data !== 32'd12) begin n_err++; $display("FAIL b2b_x3 got=x%0d:%0d exp=x3:12", wb_rd, wb_data); end
    step();
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 32'd10) begin n_err++; $display("FAIL b2b_x4 got=%b x%0d:%0d exp=1 x4:10", wb_valid, wb_rd, wb_data); end
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%b exp=0", wb_valid); end
  endtask

  task automatic test_wb_stall();
    drive_op(F3_ADD, 5, 7, 1, 2, 1'b1, 3);
    step();
    drive_op(F3_SUB, 99, 2, 3, 0, 1'b0, 4);
    wb_ready = 1'b0;
    step();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready_c1 got=%b exp=0", in_ready); end
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'd12) begin n_err++; $display("FAIL stall_data_c1 got=%b:%0d exp=1:12", wb_valid, wb_data); end
    step();
    n_cmp++; if (wb_data !== 32'd12) begin n_err++; $display("FAIL stall_data_c2 got=%0d exp=12", wb_data); end
    n_cmp++; if (alu_a !== 32'd12) begin n_err++; $display("FAIL stall_resolved_a got=%0d exp=12", alu_a); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready_c2 got=%b exp=0", in_ready); end
    step();
    n_cmp++; if (wb_data !== 32'd12 || wb_rd !== 5'd3) begin n_err++; $display("FAIL stall_data_c3 got=x%0d:%0d exp=x3:12", wb_rd, wb_data); end
    wb_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
    step();
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 32'd10) begin n_err++; $display("FAIL stall_x4 got=%b x%0d:%0d exp=1 x4:10", wb_valid, wb_rd, wb_data); end
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL stall_idle got=%b exp=0", wb_valid); end
  endtask

  task automatic test_x0_no_fwd();
    drive_op(F3_ADD, 3, 4, 1, 2, 1'b1, 0);
    step();
    drive_op(F3_OR, 8, 1, 0, 0, 1'b0, 5);
    step();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (alu_a !== 32'd8) begin n_err++; $display("FAIL x0_alu_a got=%0d exp=8", alu_a); end
    n_cmp++; if (alu_ctrl !== F3_OR) begin n_err++; $display("FAIL x0_alu_ctrl got=%0d exp=%0d", alu_ctrl, F3_OR); end
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd0 || wb_data !== 32'd7) begin n_err++; $display("FAIL x0_rd0_wb got=%b x%0d:%0d exp=1 x0:7", wb_valid, wb_rd, wb_data); end
    step();
    n_cmp++; if (wb_rd !== 5'd5 || wb_data !== 32'd9) begin n_err++; $display("FAIL x0_x5 got=x%0d:%0d exp=x5:9", wb_rd, wb_data); end
    step();
  endtask

  task automatic test_unsupported();
    drive_op(3'b011, 5, 5, 1, 2, 1'b1, 7);
    step();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (alu_ctrl !== 3'b011) begin n_err++; $display("FAIL unsup_ctrl got=%0d exp=3", alu_ctrl); end
    step();
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'd0) begin n_err++; $display("FAIL unsup_wb got=%b x%0d:%0d exp=1 x7:0", wb_valid, wb_rd, wb_data); end
    step();
  endtask

  task automatic test_flush();
    drive_op(F3_ADD, 5, 7, 1, 2, 1'b1, 3);
    step();
    drive_op(F3_SUB, 99, 2, 3, 0, 1'b0, 4);
    wb_ready = 1'b0;
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'd12) begin n_err++; $display("FAIL flush_r_kept got=%b x%0d:%0d exp=1 x3:12", wb_valid, wb_rd, wb_data); end
    // x3 is stalled in R: a new reader must take the held value
    drive_op(F3_ADD, 99, 1, 3, 0, 1'b0, 8);
    step();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (alu_a !== 32'd12) begin n_err++; $display("FAIL flush_fwd_r got=%0d exp=12", alu_a); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_stall_ready got=%b exp=0", in_ready); end
    wb_ready = 1'b1;
    #1;
    n_cmp++; if (wb_rd !== 5'd3 || wb_data !== 32'd12) begin n_err++; $display("FAIL flush_x3 got=x%0d:%0d exp=x3:12", wb_rd, wb_data); end
    step();
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd8 || wb_data !== 32'd13) begin n_err++; $display("FAIL flush_x8 got=%b x%0d:%0d exp=1 x8:13", wb_valid, wb_rd, wb_data); end
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_x4 got=%b x%0d exp=0", wb_valid, wb_rd); end
  endtask

  task automatic test_reset_mid_stall();
    drive_op(F3_ADD, 5, 7, 1, 2, 1'b1, 3);
    step();
    drive_op(F3_SUB, 99, 2, 3, 0, 1'b0, 4);
    wb_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL arst_wb_valid got=%b exp=0", wb_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (alu_a !== 32'd0) begin n_err++; $display("FAIL arst_alu_a got=%0d exp=0", alu_a); end
    @(negedge clk);
    rst = 1'b1;
    wb_ready = 1'b1;
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL arst_after got=%b exp=0", wb_valid); end
    drive_op(F3_ADD, 1, 1, 1, 2, 1'b1, 6);
    step();
    in_valid = 1'b0;
    step();
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd6 || wb_data !== 32'd2) begin n_err++; $display("FAIL arst_new_add got=%b x%0d:%0d exp=1 x6:2", wb_valid, wb_rd, wb_data); end
    step();
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_funct3 = '0; in_op_a = '0; in_op_b = '0;
    in_rs1 = '0; in_rs2 = '0; in_b_is_reg = 1'b0; in_rd = '0;
    flush = 1'b0; wb_ready = 1'b1;
    test_reset();
    test_basic_add();
    test_back_to_back();
    test_wb_stall();
    test_x0_no_fwd();
    test_unsupported();
    test_flush();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
